ifetch_ctrl: RTL and testbench
==============================

# ifetch_ctrl

Instruction-fetch controller for the pipelined MIPS core. Owns the program counter, drives the combinational instruction ROM address, and loads the IF/ID pipeline register. It arbitrates every PC redirect source by fixed priority: EX-stage branch, ID-stage illegal-op trap, ID-stage jump, external interrupt, halt, hazard stall and sequential fetch. Supervisor mode is PC[31], per the core's exception scheme.

## Interface
- RESET_PC, 32'h0000_0000: PC after reset.
- ILLOP_PC, 32'h8000_0004: illegal-opcode trap vector.
- XADR_PC, 32'h8000_0008: interrupt vector.
- HALT_OP, 6'h3F: opcode (instr[31:26]) that halts fetch.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- rom_addr  out  32  byte address to ROM; always equals pc.
- rom_data  in  32  ROM word, combinational from rom_addr.
- stall_i  in  1  load-use hazard; hold PC and IF/ID.
- branch_taken_i  in  1  EX branch resolved taken.
- branch_target_i  in  32  EX branch target.
- jump_i  in  1  ID jump (j/jal/jr/jalr).
- jump_target_i  in  32  ID jump target.
- illop_i  in  1  ID detected an undefined opcode.
- irq_i  in  1  level interrupt request.
- irq_ack_o  out  1  one-cycle pulse when the interrupt is taken.
- epc_o  out  32  return PC, valid with irq_ack_o.
- ifid_instr  out  32  IF/ID instruction.
- ifid_pc4  out  32  IF/ID PC+4.
- ifid_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  fetch stopped at a HALT_OP word.

## Operation
- pc_plus4 = {pc[31], pc[30:0] + 4}. Bit 31 is preserved and the lower 31 bits wrap modulo 2^31. Redirect targets are loaded as given, all 32 bits.
- A bubble is defined as ifid_instr = 0, ifid_pc4 = 0, ifid_valid = 0.
- Each cycle, exactly one action is selected, highest priority first:
  1. branch_taken_i: pc <= branch_target_i; IF/ID <= bubble; halted <= 0.
  2. illop_i: pc <= ILLOP_PC; IF/ID <= bubble; halted <= 0.
  3. jump_i: pc <= jump_target_i; IF/ID <= bubble; halted <= 0.
  4. Interrupt: taken when irq_i=1, pc[31]=0 and stall_i=0. Then pc <= XADR_PC; IF/ID <= bubble; irq_ack_o=1; epc_o=pc; halted <= 0.
  5. Halted (halted=1): pc holds; IF/ID <= bubble.
  6. stall_i: pc and IF/ID hold unchanged.
  7. Halt detect (rom_data[31:26]==HALT_OP): pc holds; halted <= 1; IF/ID <= bubble. The halt word is never issued.
  8. Sequential: pc <= pc_plus4; ifid_instr <= rom_data; ifid_pc4 <= pc_plus4; ifid_valid <= 1.
- There is no branch delay slot. The word fetched in the redirect cycle is always squashed.
- A redirect overrides stall_i, because the stalled ID instruction is squashed downstream.
- Interrupts are masked in supervisor mode (pc[31]=1) and while stall_i=1. A pending irq_i is taken in the first eligible cycle.
- An address outside the ROM returns 0 (sll nop) and is fetched normally.

## Timing
- Reset (asynchronous assert, synchronous-safe release): pc=RESET_PC, IF/ID=bubble, halted=0. irq_ack_o=0 and epc_o=0 combinationally during reset.
- rom_addr follows pc combinationally, so fetch-to-IF/ID latency is 1 cycle.
- A redirect asserted in cycle N appears on rom_addr in cycle N+1. The first valid target instruction appears in IF/ID in cycle N+2.
- irq_ack_o and epc_o are combinational in the take cycle and low otherwise. epc_o is the address of the squashed, not-yet-issued instruction.
- If reset asserts mid-stall or mid-halt, all state returns to reset values immediately.

## Test plan
- Reset and sequential fetch: release reset -> rom_addr 0,4,8,… on successive cycles. ifid_instr equals the ROM word from the prior cycle, with ifid_valid=1 from cycle 1.
- Stall: hold stall_i for 2 cycles at pc=0x0C -> pc stays 0x0C and IF/ID is unchanged. On release, pc=0x10 the next cycle.
- Branch vs. jump vs. stall in the same cycle: branch_taken_i=1 (target 0x04), jump_i=1 (target 0x40), stall_i=1 -> pc=0x04 next and IF/ID is a bubble.
- Interrupt: irq_i=1 at pc=0x20 -> irq_ack_o pulse, epc_o=0x20, pc=0x8000_0008. With irq_i held in supervisor mode, no second ack occurs.
- Illegal op: illop_i=1 -> pc=0x8000_0004, IF/ID is a bubble, and pc_plus4 keeps bit 31 (0x8000_0008 next).
- Halt: word 0xFC000000 at pc=0x68 -> halted=1, pc frozen at 0x68, and bubbles issue indefinitely. A later branch_taken_i to 0x00 clears halted and fetch resumes at 0x00.

Source files
------------

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: owns the PC, drives the ROM address
// and loads the IF/ID register under a fixed redirect priority.
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] ILLOP_PC = 32'h8000_0004,
  parameter logic [31:0] XADR_PC  = 32'h8000_0008,
  parameter logic [5:0]  HALT_OP  = 6'h3F
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        illop_i,
  input  logic        irq_i,
  output logic        irq_ack_o,
  output logic [31:0] epc_o,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        halted
);

  typedef enum logic {
    S_RUN,
    S_HALT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic [31:0] pc_plus4;
  logic        irq_ok;
  logic        is_halt_op;

  logic sel_br, sel_ill, sel_jmp, sel_irq;
  logic sel_hlt, sel_stl, sel_hdet, sel_seq;

  // Bit 31 (supervisor) survives sequential fetch; low bits wrap.
  assign pc_plus4   = {pc_q[31], pc_q[30:0] + 31'd4};
  assign irq_ok     = irq_i & ~pc_q[31] & ~stall_i;
  assign is_halt_op = (rom_data[31:26] == HALT_OP);

  // Priority-encode the redirect sources into one-hot selects.
  always_comb begin
    sel_br   = 1'b0;
    sel_ill  = 1'b0;
    sel_jmp  = 1'b0;
    sel_irq  = 1'b0;
    sel_hlt  = 1'b0;
    sel_stl  = 1'b0;
    sel_hdet = 1'b0;
    sel_seq  = 1'b0;
    if (branch_taken_i)        sel_br   = 1'b1;
    else if (illop_i)          sel_ill  = 1'b1;
    else if (jump_i)           sel_jmp  = 1'b1;
    else if (irq_ok)           sel_irq  = 1'b1;
    else if (state_q == S_HALT) sel_hlt = 1'b1;
    else if (stall_i)          sel_stl  = 1'b1;
    else if (is_halt_op)       sel_hdet = 1'b1;
    else                       sel_seq  = 1'b1;
  end

  // Next PC, IF/ID contents and run/halt state for the chosen action.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    state_d = state_q;
    unique case (1'b1)
      sel_br: begin
        pc_d    = branch_target_i;
        instr_d = '0;
        pc4_d   = '0;
        valid_d = 1'b0;
        state_d = S_RUN;
      end
      sel_ill: begin
        pc_d    = ILLOP_PC;
        instr_d = '0;
        pc4_d   = '0;
        valid_d = 1'b0;
        state_d = S_RUN;
      end
      sel_jmp: begin
        pc_d    = jump_target_i;
        instr_d = '0;
        pc4_d   = '0;
        valid_d = 1'b0;
        state_d = S_RUN;
      end
      sel_irq: begin
        pc_d    = XADR_PC;
        instr_d = '0;
        pc4_d   = '0;
        valid_d = 1'b0;
        state_d = S_RUN;
      end
      sel_hlt: begin
        instr_d = '0;
        pc4_d   = '0;
        valid_d = 1'b0;
      end
      sel_stl: begin
        pc_d = pc_q;
      end
      sel_hdet: begin
        instr_d = '0;
        pc4_d   = '0;
        valid_d = 1'b0;
        state_d = S_HALT;
      end
      sel_seq: begin
        pc_d    = pc_plus4;
        instr_d = rom_data;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  // PC, IF/ID and run/halt state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign rom_addr   = pc_q;
  assign ifid_instr = instr_q;
  assign ifid_pc4   = pc4_q;
  assign ifid_valid = valid_q;
  assign halted     = (state_q == S_HALT);

  // The ack is forced low while reset is held.
  assign irq_ack_o = sel_irq & reset;
  assign epc_o     = (sel_irq & reset) ? pc_q : 32'h0;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Randomized bench for ifetch_ctrl against a
// cycle-level priority model of the fetch rules.
module tb_ifetch_ctrl;

  localparam logic [31:0] ILLOP = 32'h8000_0004;
  localparam logic [31:0] XADR  = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        stall_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        jump_i;
  logic [31:0] jump_target_i;
  logic        illop_i;
  logic        irq_i;
  logic        irq_ack_o;
  logic [31:0] epc_o;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        halted;

  logic [31:0] rom [64];

  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_halt;

  int n_chk  = 0;
  int n_pass = 0;

  ifetch_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .rom_addr        (rom_addr),
    .rom_data        (rom_data),
    .stall_i         (stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .illop_i         (illop_i),
    .irq_i           (irq_i),
    .irq_ack_o       (irq_ack_o),
    .epc_o           (epc_o),
    .ifid_instr      (ifid_instr),
    .ifid_pc4        (ifid_pc4),
    .ifid_valid      (ifid_valid),
    .halted          (halted)
  );

  always #5 clk = ~clk;

  always_comb begin
    if (rom_addr[31:8] == 24'h0) rom_data = rom[rom_addr[7:2]];
    else                         rom_data = 32'h0;
  end

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a < 32'h100) return rom[a >> 2];
    return 32'h0;
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic bub();
    m_instr = 32'h0;
    m_pc4   = 32'h0;
    m_valid = 1'b0;
  endtask

  task automatic model_reset();
    m_pc   = 32'h0;
    m_halt = 1'b0;
    bub();
  endtask

  // One clock: starts and ends just after a falling edge.
  task automatic cyc(input logic br, input logic [31:0] bt,
                     input logic jp, input logic [31:0] jt,
                     input logic il, input logic st,
                     input logic iq);
    logic        take;
    logic [31:0] w;
    branch_taken_i  = br;
    branch_target_i = bt;
    jump_i          = jp;
    jump_target_i   = jt;
    illop_i         = il;
    stall_i         = st;
    irq_i           = iq;
    #1;
    take = !br && !il && !jp && iq && (m_pc < 32'h8000_0000) && !st;
    check("rom_addr", rom_addr, m_pc);
    check("irq_ack", {31'h0, irq_ack_o}, {31'h0, take});
    check("epc", epc_o, take ? m_pc : 32'h0);
    w = rom_word(m_pc);
    if (br) begin
      m_pc = bt; bub(); m_halt = 1'b0;
    end else if (il) begin
      m_pc = ILLOP; bub(); m_halt = 1'b0;
    end else if (jp) begin
      m_pc = jt; bub(); m_halt = 1'b0;
    end else if (take) begin
      m_pc = XADR; bub(); m_halt = 1'b0;
    end else if (m_halt) begin
      bub();
    end else if (st) begin
      m_halt = m_halt;
    end else if ((w >> 26) == 32'h3F) begin
      m_halt = 1'b1; bub();
    end else begin
      m_instr = w;
      m_pc4   = (m_pc & 32'h8000_0000)
              | ((m_pc + 32'd4) & 32'h7FFF_FFFF);
      m_pc    = m_pc4;
      m_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    check("ifid_instr", ifid_instr, m_instr);
    check("ifid_pc4", ifid_pc4, m_pc4);
    check("ifid_valid", {31'h0, ifid_valid}, {31'h0, m_valid});
    check("halted", {31'h0, halted}, {31'h0, m_halt});
    @(negedge clk);
  endtask

  task automatic seq(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset in the middle of a cycle.
  task automatic do_reset();
    #2;
    reset   = 1'b0;
    stall_i = 1'b1;
    irq_i   = 1'b1;
    #1;
    model_reset();
    check("rst_addr", rom_addr, 32'h0);
    check("rst_instr", ifid_instr, 32'h0);
    check("rst_pc4", ifid_pc4, 32'h0);
    check("rst_valid", {31'h0, ifid_valid}, 32'h0);
    check("rst_halted", {31'h0, halted}, 32'h0);
    check("rst_ack", {31'h0, irq_ack_o}, 32'h0);
    check("rst_epc", epc_o, 32'h0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [31:0] rand_tgt();
    logic [31:0] t;
    t = 32'($urandom_range(63)) << 2;
    if ($urandom_range(7) == 0) t = t | 32'h8000_0000;
    return t;
  endfunction

  initial begin
    logic [31:0] w;
    reset           = 1'b0;
    stall_i         = 1'b0;
    branch_taken_i  = 1'b0;
    branch_target_i = 32'h0;
    jump_i          = 1'b0;
    jump_target_i   = 32'h0;
    illop_i         = 1'b0;
    irq_i           = 1'b0;
    for (int i = 0; i < 64; i++) rom[i] = 32'h0100_0000 | 32'(i);
    rom[26] = 32'hFC00_0000;
    model_reset();
    #1;
    check("init_addr", rom_addr, 32'h0);
    check("init_valid", {31'h0, ifid_valid}, 32'h0);
    check("init_halted", {31'h0, halted}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    seq(3);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    check("stall_hold", rom_addr, 32'h0C);
    seq(1);
    check("stall_rel", rom_addr, 32'h10);

    cyc(1, 32'h04, 1, 32'h40, 0, 1, 0);
    check("br_win", rom_addr, 32'h04);
    check("br_bubble", {31'h0, ifid_valid}, 32'h0);
    seq(7);
    check("at_20", rom_addr, 32'h20);
    cyc(0, 0, 0, 0, 0, 0, 1);
    check("irq_vec", rom_addr, XADR);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 1);

    cyc(0, 0, 0, 0, 1, 0, 0);
    check("illop_vec", rom_addr, ILLOP);
    seq(1);
    check("illop_pc4", rom_addr, 32'h8000_0008);

    cyc(0, 0, 1, 32'h60, 0, 0, 0);
    seq(3);
    seq(4);
    check("halt_pc", rom_addr, 32'h68);
    check("halt_flag", {31'h0, halted}, 32'h1);
    cyc(1, 32'h0, 0, 0, 0, 0, 0);
    check("unhalt", {31'h0, halted}, 32'h0);
    seq(3);

    cyc(0, 0, 1, 32'h7FFF_FFFC, 0, 0, 0);
    seq(2);
    check("wrap_lo", rom_addr, 32'h4);
    cyc(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
    seq(2);
    check("wrap_hi", rom_addr, 32'h8000_0004);

    cyc(0, 0, 1, 32'h10, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 32'h0, 0, 0, 0);
    seq(2);
    cyc(0, 0, 0, 0, 0, 1, 0);
    do_reset();

    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      if ($urandom_range(15) == 0) w[31:26] = 6'h3F;
      else if (w[31:26] == 6'h3F) w[26] = 1'b0;
      rom[i] = w;
    end
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(249) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(15) == 0, rand_tgt(),
            $urandom_range(15) == 0, rand_tgt(),
            $urandom_range(31) == 0,
            $urandom_range(3) == 0,
            $urandom_range(7) == 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
